p66btxgears: RTL and testbench

Transmit-side 66b-to-32b gearbox for the 10Gb Ethernet PCS. It accepts one 66-bit scrambled block per handshake from the encoder/scrambler and emits one 32-bit word every clock to the serializer. Bits go out LSB-first, sync header first, so the far-end receive gearbox recovers the identical 66-bit stream. It also inserts a fill block when the upstream source fails to supply a block on a granted cycle.

---
 rtl/p66btxgears.sv | 68 ++++++
 tb/tb_p66btxgears.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/p66btxgears.sv
// 66b-to-32b transmit gearbox: packs scrambled 66-bit blocks into a continuous
// 32-bit LSB-first word stream, inserting a fill block when the source starves.
module p66btxgears #(
  parameter logic [65:0] FILL_BLOCK = 66'h00000000000000_1E_2,
  parameter int          CNTW       = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            S_VALID,
  output logic            S_READY,
  input  logic [65:0]     S_DATA,
  output logic            o_valid,
  output logic [31:0]     o_data,
  output logic            o_underflow,
  output logic [CNTW-1:0] o_fill_count
);

  // Handshake: a block transfers on every rising edge where S_READY is high.
  // S_READY depends only on registered state; S_VALID low on a grant inserts
  // FILL_BLOCK instead of stalling, since the serializer never pauses.

  logic [65:0]     r_sreg;
  logic [6:0]      r_count;
  logic [31:0]     r_data;
  logic            r_valid;
  logic            r_underflow;
  logic [CNTW-1:0] r_fill_count;

  logic            w_load;
  logic            w_starve;
  logic [65:0]     w_word;
  logic [97:0]     w_full;
  logic [6:0]      w_ncount;

  assign w_load   = (r_count < 7'd32);
  assign w_starve = w_load && !S_VALID;
  assign w_word   = S_VALID ? S_DATA : FILL_BLOCK;

  // Bits at and above r_count are zero, so OR-ing the shifted block appends it.
  assign w_full   = {32'b0, r_sreg} | (w_load ? ({32'b0, w_word} << r_count) : 98'b0);
  assign w_ncount = r_count + (w_load ? 7'd66 : 7'd0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sreg       <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_underflow  <= 1'b0;
      r_fill_count <= '0;
    end else begin
      r_data      <= w_full[31:0];
      r_sreg      <= w_full[97:32];
      r_count     <= w_ncount - 7'd32;
      r_valid     <= 1'b1;
      r_underflow <= w_starve;
      if (w_starve && (r_fill_count != {CNTW{1'b1}}))
        r_fill_count <= r_fill_count + CNTW'(1);
    end
  end

  assign S_READY      = w_load;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_underflow  = r_underflow;
  assign o_fill_count = r_fill_count;

endmodule

// File: tb/tb_p66btxgears.sv
// Randomized scoreboard bench for p66btxgears: a bit-level queue model of the
// serialized stream predicts every output word, grant, underflow and fill count.
module tb_p66btxgears;

  localparam int          CNTW = 3;
  localparam logic [65:0] FILL = 66'h00000000000000_1E_2;

  logic            i_clk;
  logic            i_reset_n;
  logic            S_VALID;
  logic            S_READY;
  logic [65:0]     S_DATA;
  logic            o_valid;
  logic [31:0]     o_data;
  logic            o_underflow;
  logic [CNTW-1:0] o_fill_count;

  p66btxgears #(.FILL_BLOCK(FILL), .CNTW(CNTW)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .S_DATA       (S_DATA),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_underflow  (o_underflow),
    .o_fill_count (o_fill_count)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // scoreboard state: serialized bits not yet seen on o_data, oldest first
  logic [0:0]      exp_q[$];
  logic            uf_q[$];
  logic [CNTW-1:0] fc_q[$];
  logic [CNTW-1:0] model_fc;
  int              checks;
  int              failures;
  int              n_ready;

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver: call at a falling edge; applies inputs for the next rising edge
  task automatic drive_cycle(input logic v, input logic [65:0] d, output logic granted);
    logic [65:0] w;
    S_VALID = v;
    S_DATA  = d;
    granted = (exp_q.size() < 32);
    chk("s_ready", {65'b0, S_READY}, {65'b0, granted});
    if (granted) begin
      n_ready++;
      w = v ? d : FILL;
      for (int k = 0; k < 66; k++) exp_q.push_back(w[k]);
      if (!v && model_fc != {CNTW{1'b1}}) model_fc++;
    end
    uf_q.push_back(granted && !v);
    fc_q.push_back(model_fc);
    @(negedge i_clk);
  endtask

  function automatic logic [65:0] rand_block();
    logic [1:0] hdr;
    hdr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    return {32'($urandom), 32'($urandom), hdr};
  endfunction

  // monitor: one output word per clock after each driven cycle
  initial begin
    logic [31:0] exp_w;
    forever begin
      @(posedge i_clk);
      #1;
      if (uf_q.size() > 0) begin
        if (exp_q.size() < 32) begin
          checks++;
          failures++;
          $display("FAIL model_underrun got=%0d bits exp>=32", exp_q.size());
          exp_q.delete();
        end else begin
          for (int k = 0; k < 32; k++) exp_w[k] = exp_q.pop_front();
          chk("o_data", {34'b0, o_data}, {34'b0, exp_w});
        end
        chk("o_valid", {65'b0, o_valid}, 66'd1);
        chk("o_underflow", {65'b0, o_underflow}, {65'b0, uf_q.pop_front()});
        chk("o_fill_count", {{(66-CNTW){1'b0}}, o_fill_count}, {{(66-CNTW){1'b0}}, fc_q.pop_front()});
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_o_valid"}, {65'b0, o_valid}, 66'd0);
    chk({tag, "_o_data"}, {34'b0, o_data}, 66'd0);
    chk({tag, "_o_underflow"}, {65'b0, o_underflow}, 66'd0);
    chk({tag, "_o_fill_count"}, {{(66-CNTW){1'b0}}, o_fill_count}, 66'd0);
    chk({tag, "_s_ready"}, {65'b0, S_READY}, 66'd1);
  endtask

  initial begin
    logic        g;
    logic        found;
    logic [63:0] idx;
    int          accepted;
    int          starved;

    checks   = 0;
    failures = 0;
    n_ready  = 0;
    model_fc = '0;
    S_VALID  = 1'b0;
    S_DATA   = '0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_values("reset");
    i_reset_n = 1'b1;

    // first block, then counter stream with S_VALID held high
    drive_cycle(1'b1, 66'h3_FFFF_FFFF_0000_0001, g);
    idx = 64'd1;
    accepted = 1;
    for (int c = 1; c < 33; c++) begin
      drive_cycle(1'b1, {idx, 2'b01}, g);
      if (g) begin idx++; accepted++; end
    end
    chk("ready_per_33", 66'(n_ready), 66'd16);
    n_ready = 0;
    for (int c = 0; c < 330; c++) begin
      drive_cycle(1'b1, {idx, 2'b01}, g);
      if (g) begin idx++; accepted++; end
    end
    chk("ready_per_330", 66'(n_ready), 66'd160);
    for (int c = 0; c < 30000 && accepted < 10000; c++) begin
      drive_cycle(1'b1, {idx, 2'b01}, g);
      if (g) begin idx++; accepted++; end
    end
    chk("blocks_accepted", 66'(accepted), 66'd10000);
    chk("fill_after_stream", {{(66-CNTW){1'b0}}, o_fill_count}, 66'd0);

    // single starvation on a granted cycle, garbage on S_DATA
    starved = 0;
    for (int c = 0; c < 100; c++) begin
      if (starved == 0 && exp_q.size() < 32 && c > 10) begin
        drive_cycle(1'b0, rand_block(), g);
        starved = 1;
      end else begin
        drive_cycle(1'b1, {idx, 2'b01}, g);
        if (g) idx++;
      end
    end
    chk("fill_after_starve", {{(66-CNTW){1'b0}}, o_fill_count}, 66'd1);

    // random valid/data; data churns while not granted; fill count saturates
    for (int c = 0; c < 3000; c++)
      drive_cycle($urandom_range(0, 3) != 0, rand_block(), g);
    chk("fill_saturated", {{(66-CNTW){1'b0}}, o_fill_count}, {{(66-CNTW){1'b0}}, {CNTW{1'b1}}});

    // reset asynchronously while 36 bits are buffered
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (exp_q.size() == 36) found = 1'b1;
      else drive_cycle(1'b1, rand_block(), g);
    end
    chk("found_count36", {65'b0, found}, 66'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    model_fc = '0;
    repeat (2) @(negedge i_clk);
    check_reset_values("midreset_held");
    i_reset_n = 1'b1;
    for (int c = 0; c < 200; c++)
      drive_cycle($urandom_range(0, 7) != 0, rand_block(), g);

    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
